// File: rtl/aq_gemac_pkg.sv
// aq_gemac_pkg: shared GEMAC byte/CRC constants and TX framer state encoding
package aq_gemac_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_PRE   = 3'd1;
  localparam logic [2:0]  ST_DATA  = 3'd2;
  localparam logic [2:0]  ST_DRAIN = 3'd3;
  localparam logic [2:0]  ST_PAD   = 3'd4;
  localparam logic [2:0]  ST_FCS   = 3'd5;
  localparam logic [2:0]  ST_IFG   = 3'd6;
endpackage

// File: rtl/aq_gemac_crc32_d8.sv
// aq_gemac_crc32_d8: next reflected CRC-32 state after one byte, LSB first
module aq_gemac_crc32_d8
  import aq_gemac_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  always_comb begin
    o_crc = i_crc;
    for (int i = 0; i < 8; i++)
      o_crc = (o_crc[0] ^ i_data[i]) ? (o_crc >> 1) ^ CRC32_POLY_REFL : o_crc >> 1;
  end
endmodule

// File: rtl/aq_gemac_gmii_tx_framer.sv
// aq_gemac_gmii_tx_framer: wraps a content byte stream in preamble/SFD, pad, FCS and IFG on GMII TX
module aq_gemac_gmii_tx_framer
  import aq_gemac_pkg::*;
#(
  parameter bit PAD_EN  = 1'b1,
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_txe,
  output logic       gmii_txer,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);
  logic [2:0]  r_state;
  logic [10:0] r_cnt, r_ph, w_cnt_inc;
  logic [31:0] r_crc, w_crc_nxt;
  logic [7:0]  w_crc_din;
  logic        w_pad_more;
  assign s_ready    = (r_state == ST_DATA) || (r_state == ST_DRAIN);
  assign busy       = r_state != ST_IDLE;
  assign w_cnt_inc  = &r_cnt ? r_cnt : r_cnt + 11'd1;
  assign w_pad_more = PAD_EN && (w_cnt_inc < 11'(MIN_LEN));
  assign w_crc_din  = (r_state == ST_DATA) ? s_data : 8'h00;
  aq_gemac_crc32_d8 u_crc (.i_crc(r_crc), .i_data(w_crc_din), .o_crc(w_crc_nxt));
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ph       <= '0;
      r_crc      <= '0;
      gmii_txd   <= 8'h00;
      gmii_txe   <= 1'b0;
      gmii_txer  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      gmii_txd   <= 8'h00;
      gmii_txe   <= 1'b0;
      gmii_txer  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_ph  <= '0;
          if (s_valid) r_state <= ST_PRE;
        end
        ST_PRE: begin
          gmii_txe <= 1'b1;
          gmii_txd <= (r_ph == 11'd7) ? SFD_BYTE : PREAMBLE_BYTE;
          r_crc    <= CRC32_INIT;
          r_ph     <= (r_ph == 11'd7) ? 11'd0 : r_ph + 11'd1;
          if (r_ph == 11'd7) r_state <= ST_DATA;
        end
        ST_DATA: begin
          gmii_txe <= 1'b1;
          if (s_valid) begin
            gmii_txd <= s_data;
            r_crc    <= w_crc_nxt;
            r_cnt    <= w_cnt_inc;
            if (s_last) r_state <= w_pad_more ? ST_PAD : ST_FCS;
          end else begin
            // starved mid-frame: poison the frame on the wire and swallow the rest of it
            gmii_txer <= 1'b1;
            underrun  <= 1'b1;
            r_state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (s_valid && s_last) r_state <= ST_IFG;
        ST_PAD: begin
          gmii_txe <= 1'b1;
          r_crc    <= w_crc_nxt;
          r_cnt    <= w_cnt_inc;
          if (!w_pad_more) r_state <= ST_FCS;
        end
        ST_FCS: begin
          gmii_txe   <= 1'b1;
          gmii_txd   <= ~r_crc[{r_ph[1:0], 3'b000} +: 8];
          frame_done <= r_ph == 11'd3;
          r_ph       <= (r_ph == 11'd3) ? 11'd0 : r_ph + 11'd1;
          if (r_ph == 11'd3) r_state <= ST_IFG;
        end
        ST_IFG: begin
          r_ph <= r_ph + 11'd1;
          if (r_ph == 11'(IFG_LEN - 1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aq_gemac_gmii_tx_framer.sv
// tb_aq_gemac_gmii_tx_framer: scoreboard bench for a padding framer and a non-padding framer
module tb_aq_gemac_gmii_tx_framer;
  typedef struct packed {logic no_rdy; logic sfd; logic [10:0] v;} ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic s_last = 1'b0, s_valid_p = 1'b0, s_valid_n = 1'b0;
  logic rdy_p, txe_p, txer_p, busy_p, fd_p, ur_p, rdy_n, txe_n, txer_n, busy_n, fd_n, ur_n;
  logic [7:0] txd_p, txd_n;
  ent_t q_p[$], q_n[$];
  int n_vec = 0, n_err = 0;
  logic [31:0] rc[2], resid[2], fcs[2], sh[2];
  int nb[2], nbytes[2], fdc[2], gap_run[2], brun[2];
  bit gap_on[2], bchk[2];
  bit b2b = 1'b0;
  always #4 clk = ~clk;
  aq_gemac_gmii_tx_framer #(.PAD_EN(1'b1), .MIN_LEN(60), .IFG_LEN(12)) u_dut (
    .tx_clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid_p), .s_last(s_last), .s_ready(rdy_p),
    .gmii_txd(txd_p), .gmii_txe(txe_p), .gmii_txer(txer_p), .busy(busy_p), .frame_done(fd_p), .underrun(ur_p));
  aq_gemac_gmii_tx_framer #(.PAD_EN(1'b0), .MIN_LEN(60), .IFG_LEN(12)) u_dut_np (
    .tx_clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid_n), .s_last(s_last), .s_ready(rdy_n),
    .gmii_txd(txd_n), .gmii_txe(txe_n), .gmii_txer(txer_n), .busy(busy_n), .frame_done(fd_n), .underrun(ur_n));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] crcb(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) x = x[0] ? (x >> 1) ^ 32'hEDB88320 : x >> 1;
    return x;
  endfunction
  function automatic ent_t mk(input logic nr, input logic sf, input logic u, input logic f, input logic e, input logic [7:0] d);
    return {nr, sf, u, f, e, d};
  endfunction
  function automatic int qsize(input int s);
    return s != 0 ? q_n.size() : q_p.size();
  endfunction
  task automatic push(input int s, input ent_t e);
    if (s != 0) q_n.push_back(e); else q_p.push_back(e);
  endtask
  task automatic set_valid(input int s, input logic v);
    if (s != 0) s_valid_n = v; else s_valid_p = v;
  endtask
  task automatic mon(input int s);
    logic [7:0] d;
    logic e, er, f, u, b, r;
    logic [10:0] act;
    ent_t x;
    d = s != 0 ? txd_n : txd_p;
    e = s != 0 ? txe_n : txe_p;
    er = s != 0 ? txer_n : txer_p;
    f = s != 0 ? fd_n : fd_p;
    u = s != 0 ? ur_n : ur_p;
    b = s != 0 ? busy_n : busy_p;
    r = s != 0 ? rdy_n : rdy_p;
    act = {u, f, er, d};
    if (!e) begin
      chk("idle_bus", 32'(act), 32'd0);
      gap_run[s]++;
    end else begin
      if (b2b && s == 0 && gap_on[0]) chk("b2b_gap", 32'(gap_run[0]), 32'd13);
      gap_on[s] = 1'b0;
      chk("txq_has_entry", 32'(qsize(s) != 0), 32'd1);
      if (qsize(s) != 0) begin
        x = (s != 0) ? q_n.pop_front() : q_p.pop_front();
        chk("txbus", 32'(act), 32'(x.v));
        if (x.no_rdy) chk("rdy_low", 32'(r), 32'd0);
        rc[s] = x.sfd ? 32'hFFFFFFFF : crcb(rc[s], d);
        nb[s] = x.sfd ? 0 : nb[s] + 1;
        sh[s] = {d, sh[s][31:8]};
        if (f) begin
          resid[s] = rc[s];
          nbytes[s] = nb[s];
          fcs[s] = sh[s];
          fdc[s]++;
          gap_on[s] = 1'b1;
          gap_run[s] = 0;
          brun[s] = 0;
          bchk[s] = 1'b1;
        end
      end
    end
    if (bchk[s]) begin
      if (b) begin
        brun[s]++;
        chk("rdy_ifg", 32'(r), 32'd0);
      end else begin
        chk("ifg_len", 32'(brun[s]), 32'd12);
        bchk[s] = 1'b0;
      end
    end
  endtask
  always @(negedge clk) for (int s = 0; s < 2; s++) mon(s);
  task automatic send(input int s, input logic [7:0] b[$], input int ur_at, input int rst_at, input bit keep);
    bit drain = 1'b0;
    logic r = 1'b0;
    int n, len;
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) push(s, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55));
    push(s, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hD5));
    for (int i = 0; i < b.size(); i++) begin
      if (i == ur_at) begin
        set_valid(s, 1'b0);
        @(posedge clk); #1;
        push(s, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00));
        drain = 1'b1;
      end
      set_valid(s, 1'b1);
      s_data = b[i];
      s_last = (i == b.size() - 1);
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_valid(s, 1'b0);
        s_last = 1'b0;
        q_p.delete();
        q_n.delete();
        chk("rst_busy", 32'(busy_p), 32'd0);
        chk("rst_txe", 32'(txe_p), 32'd0);
        chk("rst_txer", 32'(txer_p), 32'd0);
        return;
      end
      n = 0;
      do begin
        @(negedge clk);
        r = s != 0 ? rdy_n : rdy_p;
        @(posedge clk); #1;
        n++;
      end while (!r && n < 300);
      if (!r) begin
        chk("accept_timeout", 32'(r), 32'd1);
        set_valid(s, 1'b0);
        s_last = 1'b0;
        return;
      end
      if (drain) chk("drain_rdy", 32'(n), 32'd1);
      else begin
        push(s, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b[i]));
        c = crcb(c, b[i]);
      end
    end
    set_valid(s, keep);
    s_last = 1'b0;
    if (!drain) begin
      len = b.size();
      while (s == 0 && len < 60) begin
        push(s, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        c = crcb(c, 8'h00);
        len++;
      end
      c = ~c;
      for (int k = 0; k < 4; k++) push(s, mk(1'b1, 1'b0, 1'b0, k == 3, 1'b0, c[8*k +: 8]));
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while ((qsize(0) != 0 || qsize(1) != 0 || busy_p || busy_n) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("wait_done_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    logic [7:0] f[$], g[$], h[$];
    int fd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd_p), 32'd0);
    chk("rst_txe0", 32'(txe_p), 32'd0);
    chk("rst_txer0", 32'(txer_p), 32'd0);
    chk("rst_rdy", 32'(rdy_p), 32'd0);
    chk("rst_busy0", 32'(busy_p), 32'd0);
    chk("rst_fd", 32'(fd_p), 32'd0);
    chk("rst_ur", 32'(ur_p), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) f.push_back(8'(8'h31 + i));
    send(1, f, -1, -1, 1'b0);
    wait_done();
    chk("fcs_123456789", fcs[1], 32'hCBF43926);
    chk("np_frame_done", 32'(fdc[1]), 32'd1);
    chk("np_len", 32'(nbytes[1]), 32'd13);
    f.delete();
    for (int i = 0; i < 14; i++) f.push_back(8'(i * 7 + 3));
    send(0, f, -1, -1, 1'b0);
    wait_done();
    chk("pad14_resid", resid[0], 32'hDEBB20E3);
    chk("pad14_len", 32'(nbytes[0]), 32'd64);
    f.delete();
    for (int i = 0; i < 10; i++) f.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 70; i++) g.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) h.push_back(8'(8'hA0 + i));
    fd0 = fdc[0];
    gap_on[0] = 1'b0;
    b2b = 1'b1;
    send(0, f, -1, -1, 1'b1);
    send(0, g, -1, -1, 1'b1);
    send(0, h, -1, -1, 1'b0);
    wait_done();
    b2b = 1'b0;
    chk("b2b_frames", 32'(fdc[0] - fd0), 32'd3);
    chk("b2b_last_resid", resid[0], 32'hDEBB20E3);
    f.delete();
    for (int i = 0; i < 12; i++) f.push_back(8'(8'h10 + i));
    fd0 = fdc[0];
    send(0, f, 5, -1, 1'b0);
    wait_done();
    chk("ur_no_fcs", 32'(fdc[0]), 32'(fd0));
    f.delete();
    for (int i = 0; i < 30; i++) f.push_back(8'(8'hC0 + i));
    fd0 = fdc[0];
    send(0, f, -1, 19, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_fd", 32'(fdc[0]), 32'(fd0));
    f.delete();
    for (int i = 0; i < 20; i++) f.push_back(8'(8'h40 + i));
    send(0, f, -1, -1, 1'b0);
    wait_done();
    chk("post_rst_resid", resid[0], 32'hDEBB20E3);
    chk("post_rst_fd", 32'(fdc[0] - fd0), 32'd1);
    f.delete();
    f.push_back(8'h00);
    fd0 = fdc[0];
    send(0, f, -1, -1, 1'b0);
    wait_done();
    chk("one_byte_fd", 32'(fdc[0] - fd0), 32'd1);
    chk("one_byte_len", 32'(nbytes[0]), 32'd64);
    chk("one_byte_resid", resid[0], 32'hDEBB20E3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
